key_loader: RTL and testbench

Key provisioning front end for the hardware-locked RV32I core. The block accepts a serial key frame from the off-chip programming interface and checks its integrity. Once the frame is verified, it drives the unlock key to the lock modules inside the decoders and datapath. Until then it holds the key bus at zero, and it enforces a bounded number of failed load attempts.

---
 rtl/key_loader.sv | 133 +++++++++++++
 tb/tb_key_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_loader.sv
// key_loader: serial key frame receiver with XOR check byte.
// Drives the unlock key only once a frame verifies; locks out after repeated failures.
module key_loader #(
    parameter int KEY_WIDTH    = 64,
    parameter int MAX_ATTEMPTS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_start,
    input  logic                 key_valid,
    input  logic                 key_bit,
    input  logic                 key_clear,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_armed,
    output logic                 busy,
    output logic                 load_error,
    output logic                 locked_out,
    output logic [1:0]           attempts
);

    localparam int F  = KEY_WIDTH + 8;
    localparam int CW = $clog2(F + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        ARMED,
        LOCKOUT
    } state_t;

    state_t         state;
    state_t         next;
    logic [F-1:0]   sr;
    logic [CW-1:0]  cnt;
    logic [7:0]     calc;
    logic           match;
    logic           last;
    logic [1:0]     att_inc;

    always_comb begin
        calc = '0;
        for (int i = 0; i < KEY_WIDTH / 8; i++) begin
            calc = calc ^ sr[8 + 8*i +: 8];
        end
    end

    assign match   = (calc == sr[7:0]);
    assign last    = key_valid && (cnt == CW'(F - 1));
    assign att_inc = attempts + 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (key_start && !key_clear) next = LOAD;
            end
            LOAD: begin
                if (key_clear)      next = IDLE;
                else if (key_start) next = LOAD;
                else if (last)      next = CHECK;
            end
            CHECK: begin
                if (match)                            next = ARMED;
                else if (att_inc == 2'(MAX_ATTEMPTS)) next = LOCKOUT;
                else                                  next = IDLE;
            end
            ARMED: begin
                if (key_clear) next = IDLE;
            end
            LOCKOUT: next = LOCKOUT;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr         <= '0;
            cnt        <= '0;
            key_out    <= '0;
            load_error <= 1'b0;
            attempts   <= 2'd0;
        end else begin
            load_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (key_start && !key_clear) begin
                        sr  <= '0;
                        cnt <= '0;
                    end
                end
                LOAD: begin
                    if (!key_clear) begin
                        if (key_start) begin
                            sr  <= '0;
                            cnt <= '0;
                        end else if (key_valid) begin
                            sr  <= {sr[F-2:0], key_bit};
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                CHECK: begin
                    if (match) begin
                        key_out  <= sr[F-1:8];
                        attempts <= 2'd0;
                    end else begin
                        load_error <= 1'b1;
                        // lockout is entered at MAX, so this never wraps
                        if (attempts != 2'(MAX_ATTEMPTS)) attempts <= att_inc;
                    end
                end
                ARMED: begin
                    if (key_clear) key_out <= '0;
                end
                default: ;
            endcase
        end
    end

    assign key_armed  = (state == ARMED);
    assign busy       = (state == LOAD) || (state == CHECK);
    assign locked_out = (state == LOCKOUT);

endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader: directed plus randomized frames against a
// transaction-level model of the key loader.
module tb_key_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_start = 1'b0;
    logic        key_valid = 1'b0;
    logic        key_bit = 1'b0;
    logic        key_clear = 1'b0;
    logic [63:0] key_out;
    logic        key_armed;
    logic        busy;
    logic        load_error;
    logic        locked_out;
    logic [1:0]  attempts;

    int total = 0;
    int bad = 0;
    int bcnt = 0;

    int          m_att = 0;
    bit          m_locked = 0;
    bit          m_armed = 0;
    logic [63:0] m_key = '0;

    localparam logic [63:0] K = 64'hDEAD_BEEF_CAFE_F00D;

    always #5 clk = ~clk;

    key_loader #(.KEY_WIDTH(64), .MAX_ATTEMPTS(3)) dut (
        .clk(clk),
        .rst(rst),
        .key_start(key_start),
        .key_valid(key_valid),
        .key_bit(key_bit),
        .key_clear(key_clear),
        .key_out(key_out),
        .key_armed(key_armed),
        .busy(busy),
        .load_error(load_error),
        .locked_out(locked_out),
        .attempts(attempts)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (busy) bcnt++;
    endtask

    function automatic logic [7:0] xsum(logic [63:0] k);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 8; i++) s ^= k[8*i +: 8];
        return s;
    endfunction

    task automatic outs(string tag);
        check({tag, ".key"}, key_out, m_key);
        check({tag, ".armed"}, key_armed, m_armed);
        check({tag, ".locked"}, locked_out, m_locked);
        check({tag, ".att"}, attempts, m_att);
    endtask

    task automatic model_reset();
        m_att = 0;
        m_locked = 0;
        m_armed = 0;
        m_key = '0;
    endtask

    // gap: 0 contiguous, 1 every other cycle, 2 random; pre>0 restarts after pre bits
    task automatic frame(logic [63:0] k, logic [7:0] c, int gap, int pre);
        logic [71:0] f;
        bit act;
        bit was_armed;
        bit exp_err;
        int ng;
        f = {k, c};
        act = !m_locked && !m_armed;
        was_armed = m_armed;
        ng = 0;
        bcnt = 0;
        key_start = 1'b1;
        key_valid = 1'($urandom_range(0, 1));
        key_bit = 1'b1;
        step();
        key_start = 1'b0;
        check("start.busy", busy, act);
        if (pre > 0) begin
            for (int i = 0; i < pre; i++) begin
                key_valid = 1'b1;
                key_bit = 1'($urandom_range(0, 1));
                step();
            end
            bcnt = 0;
            key_start = 1'b1;
            key_valid = 1'b1;
            step();
            key_start = 1'b0;
        end
        for (int i = 0; i < 72; i++) begin
            if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 3) == 0)) begin
                key_valid = 1'b0;
                key_bit = 1'($urandom_range(0, 1));
                step();
                ng++;
            end
            key_valid = 1'b1;
            key_bit = f[71 - i];
            step();
        end
        key_valid = 1'b0;
        check("chk.busy", busy, act);
        check("chk.armed", key_armed, was_armed);
        check("chk.err", load_error, 0);
        step();
        exp_err = 0;
        if (act) begin
            if (c == xsum(k)) begin
                m_armed = 1;
                m_key = k;
                m_att = 0;
            end else begin
                exp_err = 1;
                if (m_att < 3) m_att++;
                if (m_att == 3) m_locked = 1;
            end
        end
        check("post.err", load_error, exp_err);
        check("post.busy", busy, 0);
        check("busy_cycles", bcnt, act ? 73 + ng : 0);
        outs("post");
        step();
        check("err_pulse", load_error, 0);
    endtask

    task automatic clr();
        key_clear = 1'b1;
        step();
        key_clear = 1'b0;
        if (m_armed) begin
            m_armed = 0;
            m_key = '0;
        end
        outs("clear");
    endtask

    task automatic abort_load(int n);
        if (m_armed) begin
            m_armed = 0;
            m_key = '0;
        end
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            key_valid = 1'b1;
            key_bit = 1'($urandom_range(0, 1));
            step();
        end
        key_valid = 1'b0;
        key_clear = 1'b1;
        step();
        key_clear = 1'b0;
        check("abort.busy", busy, 0);
        outs("abort");
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        outs("reset");
        check("reset.busy", busy, 0);
        check("reset.err", load_error, 0);
        step();
        rst = 1'b1;
    endtask

    initial begin
        #2;
        outs("por");
        check("por.busy", busy, 0);
        check("por.err", load_error, 0);
        step();
        step();
        rst = 1'b1;

        frame(K, 8'hEB, 0, 0);
        clr();
        frame(K, 8'hEB, 1, 0);
        clr();
        frame(K, 8'hEA, 0, 0);
        frame(K, 8'h00, 0, 0);
        frame(K, 8'h13, 2, 0);
        frame(K, 8'hEB, 0, 0);
        do_reset();

        frame(K, 8'hEB, 0, 40);
        clr();
        frame(K, 8'h55, 0, 0);
        abort_load(20);

        key_start = 1'b1;
        key_clear = 1'b1;
        step();
        key_start = 1'b0;
        key_clear = 1'b0;
        check("start_clear.busy", busy, 0);
        outs("start_clear");

        frame(K ^ 64'h1, xsum(K ^ 64'h1), 0, 0);
        clr();
        frame(K, 8'hEB, 0, 0);

        clr();
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            key_valid = 1'b1;
            key_bit = 1'($urandom_range(0, 1));
            step();
        end
        key_valid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check("async.busy", busy, 0);
        outs("async");
        step();
        rst = 1'b1;

        for (int n = 0; n < 60; n++) begin
            int r;
            logic [63:0] k;
            logic [7:0] c;
            r = $urandom_range(0, 9);
            k = {32'($urandom), 32'($urandom)};
            c = xsum(k);
            if ($urandom_range(0, 9) < 4) c ^= 8'($urandom_range(1, 255));
            if (m_locked && $urandom_range(0, 1) == 1) do_reset();
            else if (r <= 5)
                frame(k, c, $urandom_range(0, 2),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 70) : 0);
            else if (r <= 7) clr();
            else if (r == 8) abort_load($urandom_range(0, 71));
            else do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
